// File: rtl/ahb_copy_master_pkg.sv
// Shared AHB-Lite encodings and FSM state type for the AHB copy master.
package ahb_copy_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HPROT_DATA    = 3'b011;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_A,
      ST_RD_D,
      ST_WR_A,
      ST_WR_D,
      ST_DONE
   } state_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

   // Wraps modulo 2^32 by construction.
   function automatic logic [31:0] next_word(input logic [31:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/ahb_copy_master_if.sv
// AHB-Lite bus bundle between the copy master and its responder.
interface ahb_copy_master_if;

   logic [31:0] haddr;
   logic [1:0]  htrans;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [2:0]  hprot;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic [1:0]  hresp;

   modport master (
      output haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  haddr, htrans, hwrite, hsize, hburst, hprot, hwdata,
      output hrdata, hready, hresp
   );

endinterface

// File: rtl/ahb_copy_master.sv
// AHB-Lite block copy initiator: single-beat read then single-beat write per word.
// Optional fill mode (constant pattern writes) is enabled by defining AHB_COPY_FILL_EN.
module ahb_copy_master
   import ahb_copy_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic              hclk,
   input  logic              hreset,
   input  logic              start,
   input  logic [31:0]       src_addr,
   input  logic [31:0]       dst_addr,
   input  logic [LEN_W-1:0]  len,
`ifdef AHB_COPY_FILL_EN
   input  logic              fill,
   input  logic [31:0]       fill_data,
`endif
   output logic              busy,
   output logic              done,
   output logic              err,
   ahb_copy_master_if.master bus
);

   state_t            r_state;
   logic [31:0]       r_haddr;
   logic [1:0]        r_htrans;
   logic              r_hwrite;
   logic [31:0]       r_hwdata;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [31:0]       r_src;
   logic [31:0]       r_dst;
   logic [LEN_W-1:0]  r_cnt;
   logic [31:0]       r_hold;

   logic              w_fill_req;
   logic [31:0]       w_fill_word;
   logic              w_fill_mode;
   logic              w_resp_ok;
   logic              w_accept;

   assign w_resp_ok = (bus.hresp == HRESP_OKAY);
   assign w_accept  = (r_state == ST_IDLE) && start;

`ifdef AHB_COPY_FILL_EN
   logic r_fill;

   always_ff @(posedge hclk) begin
      if (w_accept) r_fill <= fill;
   end

   assign w_fill_req  = fill;
   assign w_fill_word = fill_data;
   assign w_fill_mode = r_fill;
`else
   assign w_fill_req  = 1'b0;
   assign w_fill_word = '0;
   assign w_fill_mode = 1'b0;
`endif

   always_ff @(posedge hclk) begin
      if (hreset) begin
         r_state  <= ST_IDLE;
         r_haddr  <= '0;
         r_htrans <= HTRANS_IDLE;
         r_hwrite <= 1'b0;
         r_hwdata <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_err  <= 1'b0;
                  r_busy <= 1'b1;
                  if (len == '0) begin
                     r_state <= ST_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_src    <= word_align(src_addr);
                     r_dst    <= word_align(dst_addr);
                     r_cnt    <= len;
                     r_hold   <= w_fill_word;
                     r_htrans <= HTRANS_NONSEQ;
                     if (w_fill_req) begin
                        r_state  <= ST_WR_A;
                        r_haddr  <= word_align(dst_addr);
                        r_hwrite <= 1'b1;
                     end else begin
                        r_state  <= ST_RD_A;
                        r_haddr  <= word_align(src_addr);
                        r_hwrite <= 1'b0;
                     end
                  end
               end
            end
            ST_RD_A: begin
               if (bus.hready) begin
                  r_state  <= ST_RD_D;
                  r_htrans <= HTRANS_IDLE;
               end
            end
            // Data phases abort on the first ERROR cycle; the bus stays IDLE through its second cycle.
            ST_RD_D: begin
               if (!w_resp_ok) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (bus.hready) begin
                  r_hold   <= bus.hrdata;
                  r_state  <= ST_WR_A;
                  r_haddr  <= r_dst;
                  r_htrans <= HTRANS_NONSEQ;
                  r_hwrite <= 1'b1;
               end
            end
            ST_WR_A: begin
               if (bus.hready) begin
                  r_state  <= ST_WR_D;
                  r_htrans <= HTRANS_IDLE;
                  r_hwrite <= 1'b0;
                  r_hwdata <= r_hold;
               end
            end
            ST_WR_D: begin
               if (!w_resp_ok) begin
                  r_err   <= 1'b1;
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else if (bus.hready) begin
                  r_src <= next_word(r_src);
                  r_dst <= next_word(r_dst);
                  r_cnt <= r_cnt - LEN_W'(1);
                  if (r_cnt == LEN_W'(1)) begin
                     r_done  <= 1'b1;
                     r_state <= ST_DONE;
                  end else if (w_fill_mode) begin
                     r_state  <= ST_WR_A;
                     r_haddr  <= next_word(r_dst);
                     r_htrans <= HTRANS_NONSEQ;
                     r_hwrite <= 1'b1;
                  end else begin
                     r_state  <= ST_RD_A;
                     r_haddr  <= next_word(r_src);
                     r_htrans <= HTRANS_NONSEQ;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_htrans <= HTRANS_IDLE;
               r_busy   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.haddr  = r_haddr;
   assign bus.htrans = r_htrans;
   assign bus.hwrite = r_hwrite;
   assign bus.hwdata = r_hwdata;
   assign bus.hsize  = HSIZE_WORD;
   assign bus.hburst = HBURST_SINGLE;
   assign bus.hprot  = HPROT_DATA;

   assign busy = r_busy;
   assign done = r_done;
   assign err  = r_err;

endmodule

// File: doc/ahb_copy_master.md
# ahb_copy_master

AHB-Lite initiator that copies a block of 32-bit words from a source address range to a destination address range on an AHB bus. It pairs with our AHB-attached dual-port SRAM responders: firmware or the softmax engine control fabric loads source, destination and length, pulses `start`, and this master moves data into or out of those RAMs. Each word is a single-beat read followed by a single-beat write (`hburst` SINGLE), so any AHB-Lite responder is a legal target.

## Interface
- `LEN_W`, 16: width of the word-count input; maximum transfer is 2^LEN_W − 1 words.
- `hclk`  in  1  sole clock; all logic on its rising edge.
- `hreset`  in  1  reset, synchronous, active-high.
- `start`  in  1  one-cycle request; sampled only in IDLE.
- `src_addr`  in  32  byte address of first source word; bits [1:0] ignored (treated as 0).
- `dst_addr`  in  32  byte address of first destination word; bits [1:0] ignored.
- `len`  in  LEN_W  number of words to copy.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of operation (normal, zero-length or error).
- `err`  out  1  set with `done` when the operation aborted on ERROR response; cleared at next accepted `start`.
- `haddr`  out  32  AHB address.
- `htrans`  out  2  IDLE 2'b00 or NONSEQ 2'b10 only.
- `hwrite`  out  1  1 in write address phase.
- `hsize`  out  3  constant 3'b010 (word).
- `hburst`  out  3  constant 3'b000 (SINGLE).
- `hprot`  out  3  constant 3'b011 (data, privileged).
- `hwdata`  out  32  write data, valid in write data phase.
- `hrdata`  in  32  read data.
- `hready`  in  1  transfer-complete / bus-ready from responder.
- `hresp`  in  2  2'b00 OKAY, 2'b01 ERROR; other codes treated as ERROR.

## Operation
- States: IDLE, RD_A (read address phase), RD_D (read data phase), WR_A, WR_D, DONE.
- IDLE: `start`=1 with `len`≠0 → latch `src_addr`, `dst_addr`, `len` into internal registers, clear `err`, go RD_A. `len`=0 → go DONE, no bus traffic.
- RD_A: drive `haddr`=src, `htrans`=NONSEQ, `hwrite`=0; advance to RD_D on `hready`=1, else hold all outputs.
- RD_D: `htrans`=IDLE; on `hready`=1 with OKAY capture `hrdata` into 32-bit holding register, go WR_A.
- WR_A: `haddr`=dst, NONSEQ, `hwrite`=1; advance on `hready`=1.
- WR_D: `hwdata`=holding register, `htrans`=IDLE; on `hready`=1 with OKAY: src+=4, dst+=4, count−=1; count reaches 0 → DONE, else RD_A.
- ERROR response in RD_D or WR_D (`hresp`≠00, first cycle, `hready`=0): `htrans` stays IDLE, set `err`, go DONE at once without waiting for the second error cycle; the remaining words are not transferred.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE ignored; input ports need only be valid in the start cycle.
- Address arithmetic is modulo 2^32; 0xFFFFFFFC + 4 wraps to 0x00000000 with no special handling.
- `hreset` mid-transfer: next cycle all state returns to IDLE; in-flight beat abandoned; `htrans` IDLE.

## Timing
- All AHB outputs registered. Reset values: `htrans`=00, `haddr`=0, `hwrite`=0, `hwdata`=0, `busy`=0, `done`=0, `err`=0; `hsize`/`hburst`/`hprot` constant.
- `start` sampled at edge k → first NONSEQ visible in cycle k+1.
- Zero-wait responder: 4 cycles per word; `done` high in cycle k+4N+1 for N words; `len`=0 gives `done` in cycle k+1.
- Each `hready`-low cycle adds exactly one cycle to the phase it stalls.
- No address/data overlap between beats: an IDLE cycle always separates consecutive NONSEQ transfers.

## Configuration
- `AHB_COPY_FILL_EN` defined: extra inputs `fill` (1) and `fill_data` (32), sampled with `start`; `fill`=1 skips RD_A/RD_D and writes `fill_data` to N consecutive destination words, 2 cycles per word; `done` in cycle k+2N+1.
- Not defined: ports absent, copy-only behaviour above.

## Structure
- Shared package `ahb_copy_pkg`: HTRANS_IDLE/NONSEQ, HRESP_OKAY/ERROR, HSIZE_WORD, HBURST_SINGLE, HPROT_DATA constants and the state enum.
- Single module; no sub-module is natural at this size.

## Test plan
- src=0x0000_1000, dst=0x0001_0000, len=4, zero-wait RAM preloaded 0xA0..0xA3 → destination holds 0xA0..0xA3, `done` in cycle k+17, `err`=0.
- Same copy with `hready` low 2 cycles on every data phase → identical data, `done` at k+33, address/control stable during stalls.
- len=0 → no NONSEQ ever, `done` at k+1.
- ERROR on second read (word 1) → word 0 written, no write for word 1, `err`=1, `done` once, `htrans` IDLE during the error's second cycle.
- src=0xFFFF_FFF8, len=3 → reads at 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- `hreset` asserted in WR_A of word 2 → next cycle IDLE, `busy`=0, `htrans`=00; fresh `start` afterwards completes normally; with `AHB_COPY_FILL_EN`, fill 0x5A5A5A5A len=3 → `done` at k+7.
